// File: rtl/ins_mem_param_if.sv
`default_nettype none
// ============================================================================
// Module      : ins_mem_param_if
// Description : Fetch / program-load bus bundle for the instruction memory.
//               The master side drives requests and write strobes; the slave
//               side (the memory) returns read data, acks and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface ins_mem_param_if #(
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_fault;
  logic              prog_we;
  logic [31:0]       prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ack;
  logic              prog_err;
  logic              init_busy;

  modport master (
    output fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
    input  fetch_ready, fetch_valid, fetch_data, fetch_fault,
           prog_ack, prog_err, init_busy
  );

  modport slave (
    input  fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
    output fetch_ready, fetch_valid, fetch_data, fetch_fault,
           prog_ack, prog_err, init_busy
  );
endinterface
`default_nettype wire

// File: rtl/ins_mem_param.sv
`default_nettype none
// ============================================================================
// Module      : ins_mem_param
// Description : Parameterised instruction memory with one-cycle fetch port,
//               program-load write port and a self-fill initialisation phase
//               that writes FILL_WORD to every word after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_mem_param #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ins_mem_param_if.slave   bus
);

  localparam int             IW         = $clog2(DEPTH);
  localparam logic [IW-1:0]  C_CNT_LAST = IW'(DEPTH - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [IW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_fetch_valid;
  logic              r_fetch_fault;
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_prog_ack;
  logic              r_prog_err;

  logic              w_run;
  logic              w_fetch_accept;
  logic              w_prog_accept;
  logic              w_fetch_bad;
  logic              w_prog_bad;
  logic [IW-1:0]     w_fetch_idx;
  logic [IW-1:0]     w_prog_idx;

  // An address is unusable when not word aligned or when any bit above the
  // word-index field is set (shift form stays valid for every legal DEPTH).
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IW + 2)) != 32'd0);
  endfunction

  assign w_run          = (r_state == ST_RUN);
  assign w_fetch_accept = bus.fetch_req & w_run;
  assign w_prog_accept  = bus.prog_we & w_run;
  assign w_fetch_bad    = addr_bad(bus.fetch_addr);
  assign w_prog_bad     = addr_bad(bus.prog_addr);
  assign w_fetch_idx    = bus.fetch_addr[IW+1:2];
  assign w_prog_idx     = bus.prog_addr[IW+1:2];

  // Fill sequencer: walk cnt through every word, then hand over to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == C_CNT_LAST) begin
        r_state <= ST_RUN;
      end
    end
  end

  // Storage writes: fill pattern during INIT, accepted good writes in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_INIT) begin
        r_mem[r_cnt] <= FILL_WORD;
      end else if (w_prog_accept && !w_prog_bad) begin
        r_mem[w_prog_idx] <= bus.prog_data;
      end
    end
  end

  // Registered responses; the read samples the array before this edge's
  // write lands, giving read-before-write for a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fetch_data  <= '0;
      r_prog_ack    <= 1'b0;
      r_prog_err    <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_accept;
      r_fetch_fault <= w_fetch_accept & w_fetch_bad;
      if (w_fetch_accept) begin
        r_fetch_data <= w_fetch_bad ? FILL_WORD : r_mem[w_fetch_idx];
      end
      r_prog_ack    <= w_prog_accept;
      r_prog_err    <= w_prog_accept & w_prog_bad;
    end
  end

  assign bus.fetch_ready = w_run;
  assign bus.init_busy   = ~w_run;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_fault = r_fetch_fault;
  assign bus.fetch_data  = r_fetch_data;
  assign bus.prog_ack    = r_prog_ack;
  assign bus.prog_err    = r_prog_err;

endmodule
`default_nettype wire

// File: tb/tb_ins_mem_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_mem_param
// Description : Self-checking bench for ins_mem_param: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_mem_param;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 32;
  localparam logic [31:0] FILL   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ins_mem_param_if #(.DATA_W(DATA_W)) bus ();

  ins_mem_param #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .FILL_WORD (FILL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: word array plus remaining-fill-cycles counter.
  logic [31:0] ref_mem [DEPTH];
  int          fill_left = DEPTH;
  logic        exp_valid, exp_fault, exp_ack, exp_err;
  logic [31:0] exp_data;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit bad_addr(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Predict the outcome of the coming edge from the driven inputs, advance
  // one clock, then compare every output.
  task automatic cycle();
    if (rst) begin
      fill_left = DEPTH;
      foreach (ref_mem[i]) ref_mem[i] = FILL;
      exp_valid = 0; exp_fault = 0; exp_data = '0; exp_ack = 0; exp_err = 0;
    end else if (fill_left > 0) begin
      fill_left--;
      exp_valid = 0; exp_fault = 0; exp_ack = 0; exp_err = 0;
    end else begin
      exp_valid = bus.fetch_req;
      exp_fault = bus.fetch_req && bad_addr(bus.fetch_addr);
      if (bus.fetch_req)
        exp_data = bad_addr(bus.fetch_addr) ? FILL : ref_mem[int'(bus.fetch_addr / 4)];
      exp_ack = bus.prog_we;
      exp_err = bus.prog_we && bad_addr(bus.prog_addr);
      if (bus.prog_we && !bad_addr(bus.prog_addr))
        ref_mem[int'(bus.prog_addr / 4)] = bus.prog_data;
    end
    @(posedge clk);
    #1;
    chk("fetch_valid", 64'(bus.fetch_valid), 64'(exp_valid));
    chk("fetch_fault", 64'(bus.fetch_fault), 64'(exp_fault));
    chk("fetch_data",  64'(bus.fetch_data),  64'(exp_data));
    chk("prog_ack",    64'(bus.prog_ack),    64'(exp_ack));
    chk("prog_err",    64'(bus.prog_err),    64'(exp_err));
    chk("init_busy",   64'(bus.init_busy),   64'(fill_left > 0));
    chk("fetch_ready", 64'(bus.fetch_ready), 64'(fill_left == 0));
  endtask

  task automatic idle_inputs();
    bus.fetch_req = 1'b0;
    bus.prog_we   = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    cycle();
    idle_inputs();
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    cycle();
    idle_inputs();
  endtask

  initial begin
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = '0;
    rst            = 1'b1;

    // Reset held several cycles, then the 32-cycle fill.
    repeat (3) cycle();
    rst = 1'b0;
    repeat (DEPTH) cycle();

    // Fill complete: a plain in-range fetch sees the fill word.
    fetch(32'h0000_000C);
    cycle();

    // Program two words, then fetch them back-to-back.
    write(32'h0000_0000, 32'h2129_0000);
    write(32'h0000_0004, 32'h214A_0001);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0000_0000;
    cycle();
    bus.fetch_addr = 32'h0000_0004;
    cycle();
    idle_inputs();
    bus.fetch_addr = 32'h0000_0008;   // address change after accept is harmless
    cycle();

    // Misaligned and out-of-range fetches; rejected write aliasing index 0.
    fetch(32'h0000_0006);
    fetch(32'h0000_0080);
    write(32'h0000_0081, 32'hFFFF_FFFF);
    fetch(32'h0000_0000);
    fetch(32'hFFFF_FFFC);

    // Same-cycle write and fetch of one index, then re-fetch.
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 32'h0000_0010;
    bus.prog_data  = 32'hDEAD_BEEF;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0000_0010;
    cycle();
    idle_inputs();
    fetch(32'h0000_0010);

    // Reset hitting a fetch: no valid, full refill, programmed data lost.
    write(32'h0000_0008, 32'h1234_5678);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0000_0008;
    rst            = 1'b1;
    cycle();
    rst = 1'b0;
    // Requests during the fill must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      bus.fetch_req  = 1'($urandom_range(0, 1));
      bus.fetch_addr = {25'd0, 5'($urandom_range(0, DEPTH - 1)), 2'b00};
      bus.prog_we    = 1'($urandom_range(0, 1));
      bus.prog_addr  = {25'd0, 5'($urandom_range(0, DEPTH - 1)), 2'b00};
      bus.prog_data  = $urandom;
      cycle();
    end
    idle_inputs();
    fetch(32'h0000_0008);

    // Every word holds the fill pattern after the refill.
    bus.fetch_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.fetch_addr = 32'(i * 4);
      cycle();
    end
    idle_inputs();
    cycle();

    // Randomized traffic, including occasional resets.
    for (int n = 0; n < 600; n++) begin
      int sel;
      rst           = ($urandom_range(0, 199) == 0);
      bus.fetch_req = 1'($urandom_range(0, 2) != 0);
      sel           = int'($urandom_range(0, 9));
      if (sel < 7)      bus.fetch_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel < 9) bus.fetch_addr = 32'($urandom_range(0, DEPTH * 4 - 1));
      else              bus.fetch_addr = $urandom;
      bus.prog_we   = 1'($urandom_range(0, 2) == 0);
      sel           = int'($urandom_range(0, 9));
      if (sel < 8)      bus.prog_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel < 9) bus.prog_addr = 32'($urandom_range(0, DEPTH * 4 - 1));
      else              bus.prog_addr = $urandom;
      bus.prog_data = $urandom;
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
